// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Types and constants shared by the UART receive path, the baud
//               generator and reusable input-conditioning blocks.
//               - c_OVERSAMPLE_DEFAULT : sample ticks per bit period
//               - par_mode_e           : run-time parity mode
//               - rx_state_e           : receive FSM state encoding
//               - decode_parity()      : maps the 2-bit config field to a mode
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int c_OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } par_mode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } rx_state_e;

  // Encoding 2'b11 is treated as "no parity" so every field value is legal.
  function automatic par_mode_e decode_parity(input logic [1:0] cfg);
    par_mode_e mode;
    case (cfg)
      2'b01:   mode = PAR_EVEN;
      2'b10:   mode = PAR_ODD;
      default: mode = PAR_NONE;
    endcase
    return mode;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_sync
// Description : Multi-flop synchroniser for an asynchronous input followed by
//               a falling-edge detector on the synchronised value. Flops reset
//               to 1 so an idle-high line never reports a spurious edge.
// Ports       : clk      - sampling clock
//               rst_n    - asynchronous active-low reset
//               i_async  - asynchronous input
//               o_sync   - synchronised level
//               o_fall   - high for one cycle when o_sync goes 1 -> 0
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_fall = r_prev & ~r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame_checker.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame_checker
// Description : UART receiver with run-time parity (none/even/odd), 1 or 2
//               stop bits, break and overrun detection. Received words are
//               offered on a valid/ready handshake; error flags are sticky
//               until err_clr.
// Ports       : PCLK, PRESETn     - clock, async active-low reset
//               sample_tick       - OVERSAMPLE pulses per bit period
//               rx                - asynchronous serial input, idles high
//               cfg_parity        - 00/11 none, 01 even, 10 odd
//               cfg_stop2         - 1 selects two stop bits
//               err_clr           - clears all sticky flags
//               rx_ready          - consumer accepts rx_data
//               rx_data, rx_valid - received word and its valid flag
//               parity_err, framing_err, break_det, overrun_err - sticky flags
//               busy              - FSM is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame_checker
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = c_OVERSAMPLE_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 sample_tick,
  input  logic                 rx,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  input  logic                 err_clr,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 break_det,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int c_HALF  = OVERSAMPLE / 2;
  localparam int c_CNT_W = $clog2(OVERSAMPLE);
  localparam int c_BIT_W = $clog2(DATA_BITS);

  logic w_line;
  logic w_fall;

  uart_bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .i_async (rx),
    .o_sync  (w_line),
    .o_fall  (w_fall)
  );

  rx_state_e            r_state;
  rx_state_e            w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_BIT_W-1:0]   r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  par_mode_e            r_par_mode;
  logic                 r_stop2;

  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_parity_err;
  logic                 r_framing_err;
  logic                 r_break_det;
  logic                 r_overrun_err;

  // Strobes from the next-state logic to the datapath
  logic w_latch_cfg, w_cnt_clr, w_shift_en, w_par_chk;
  logic w_stop1_chk, w_stop2_chk, w_complete;

  // Start bit is checked half a bit after the edge; every later bit a full
  // bit period after the previous sample, i.e. always near bit centre.
  logic w_tick_mid, w_tick_bit;
  assign w_tick_mid = sample_tick && (r_cnt == c_CNT_W'(c_HALF - 1));
  assign w_tick_bit = sample_tick && (r_cnt == c_CNT_W'(OVERSAMPLE - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch_cfg = 1'b0;
    w_cnt_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_par_chk   = 1'b0;
    w_stop1_chk = 1'b0;
    w_stop2_chk = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nxt = START;
          w_latch_cfg = 1'b1;
          w_cnt_clr   = 1'b1;
        end
      end
      START: begin
        if (w_tick_mid) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = w_line ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_tick_bit) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == c_BIT_W'(DATA_BITS - 1))
            w_state_nxt = (r_par_mode != PAR_NONE) ? PARITY : STOP1;
        end
      end
      PARITY: begin
        if (w_tick_bit) begin
          w_par_chk   = 1'b1;
          w_state_nxt = STOP1;
        end
      end
      STOP1: begin
        if (w_tick_bit) begin
          w_stop1_chk = 1'b1;
          if (r_stop2) begin
            w_state_nxt = STOP2;
          end else begin
            w_complete  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      STOP2: begin
        if (w_tick_bit) begin
          w_stop2_chk = 1'b1;
          w_complete  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bit-period counter: free-runs on ticks while a frame is in progress.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (sample_tick && (r_state != IDLE)) begin
      r_cnt <= (r_cnt == c_CNT_W'(OVERSAMPLE - 1)) ? '0 : r_cnt + c_CNT_W'(1);
    end
  end

  // Frame datapath: config latch, bit counter, shift register, parity bit.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_par_mode <= PAR_NONE;
      r_stop2    <= 1'b0;
    end else begin
      if (w_latch_cfg) begin
        r_par_mode <= decode_parity(cfg_parity);
        r_stop2    <= cfg_stop2;
        r_bit_cnt  <= '0;
        r_par_bit  <= 1'b0;
      end
      if (w_shift_en) begin
        r_shift   <= {w_line, r_shift[DATA_BITS-1:1]};
        r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
      end
      if (w_par_chk)
        r_par_bit <= w_line;
    end
  end

  // Error events. r_par_bit is 0 when the frame carries no parity bit, so the
  // break test covers both framings.
  logic w_par_x, w_par_err, w_frame_err, w_break, w_overrun;
  assign w_par_x     = ^{r_shift, w_line};
  assign w_par_err   = w_par_chk && (((r_par_mode == PAR_EVEN) &&  w_par_x) ||
                                     ((r_par_mode == PAR_ODD)  && !w_par_x));
  assign w_frame_err = (w_stop1_chk || w_stop2_chk) && !w_line;
  assign w_break     = w_stop1_chk && !w_line && (r_shift == '0) && !r_par_bit;
  assign w_overrun   = w_complete && r_rx_valid && !rx_ready;

  // Output register and handshake. A completing word takes priority over a
  // same-cycle acceptance of the previous word.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else if (w_complete) begin
      r_rx_data  <= r_shift;
      r_rx_valid <= 1'b1;
    end else if (r_rx_valid && rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

  // Sticky flags: a new event in the clear cycle keeps the flag set.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_parity_err  <= 1'b0;
      r_framing_err <= 1'b0;
      r_break_det   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      if (w_par_err)        r_parity_err  <= 1'b1;
      else if (err_clr)     r_parity_err  <= 1'b0;
      if (w_frame_err)      r_framing_err <= 1'b1;
      else if (err_clr)     r_framing_err <= 1'b0;
      if (w_break)          r_break_det   <= 1'b1;
      else if (err_clr)     r_break_det   <= 1'b0;
      if (w_overrun)        r_overrun_err <= 1'b1;
      else if (err_clr)     r_overrun_err <= 1'b0;
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign parity_err  = r_parity_err;
  assign framing_err = r_framing_err;
  assign break_det   = r_break_det;
  assign overrun_err = r_overrun_err;
  assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_frame_checker
// Description : Directed self-checking bench. One 8-bit instance covers the
//               parity, glitch, break and overrun cases; a 7-bit instance
//               with two stop bits covers the second stop bit and the
//               asynchronous mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame_checker;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       presetn7 = 1'b0;
  logic       sample_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx7 = 1'b1;
  logic [1:0] cfg_parity = 2'b00;
  logic       cfg_stop2 = 1'b0;
  logic       err_clr = 1'b0;
  logic       rx_ready = 1'b1;
  logic       rx_ready7 = 1'b0;

  logic [7:0] rx_data;
  logic       rx_valid, parity_err, framing_err, break_det, overrun_err, busy;
  logic [6:0] rx_data7;
  logic       rx_valid7, parity_err7, framing_err7, break_det7, overrun_err7, busy7;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_frame_checker u_dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .sample_tick(sample_tick), .rx(rx),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .err_clr(err_clr),
    .rx_ready(rx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .parity_err(parity_err), .framing_err(framing_err), .break_det(break_det),
    .overrun_err(overrun_err), .busy(busy)
  );

  uart_rx_frame_checker #(.DATA_BITS(7)) u_dut7 (
    .PCLK(PCLK), .PRESETn(presetn7), .sample_tick(sample_tick), .rx(rx7),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .err_clr(err_clr),
    .rx_ready(rx_ready7), .rx_data(rx_data7), .rx_valid(rx_valid7),
    .parity_err(parity_err7), .framing_err(framing_err7), .break_det(break_det7),
    .overrun_err(overrun_err7), .busy(busy7)
  );

  always #5 PCLK = ~PCLK;

  // One-cycle tick every 4 PCLK cycles, changed on the falling edge.
  initial begin
    forever begin
      repeat (3) @(negedge PCLK);
      sample_tick = 1'b1;
      @(negedge PCLK);
      sample_tick = 1'b0;
    end
  end

  // Word monitor for the 8-bit instance: counts rising edges of rx_valid,
  // captures the word and measures how long rx_valid stays high.
  int         n_words = 0;
  logic [7:0] last_data = 8'h00;
  int         valid_run = 0;
  int         last_run = 0;
  always @(negedge PCLK) begin
    if (rx_valid) begin
      if (valid_run == 0) begin
        n_words   = n_words + 1;
        last_data = rx_data;
      end
      valid_run = valid_run + 1;
      last_run  = valid_run;
    end else begin
      valid_run = 0;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns 1 time unit after the posedge that closes the n-th tick cycle.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge PCLK);
      while (!sample_tick) @(posedge PCLK);
    end
    #1;
  endtask

  task automatic drive(input bit sel7, input logic v);
    if (sel7) rx7 = v;
    else      rx  = v;
  endtask

  task automatic send_frame(input bit sel7, input int nbits, input logic [8:0] data,
                            input bit has_par, input logic par_bit,
                            input logic stop_a, input bit has_stop2,
                            input logic stop_b);
    drive(sel7, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < nbits; i++) begin
      drive(sel7, data[i]);
      wait_ticks(16);
    end
    if (has_par) begin
      drive(sel7, par_bit);
      wait_ticks(16);
    end
    drive(sel7, stop_a);
    wait_ticks(16);
    if (has_stop2) begin
      drive(sel7, stop_b);
      wait_ticks(16);
    end
    drive(sel7, 1'b1);
  endtask

  task automatic pulse_clr();
    @(negedge PCLK);
    err_clr = 1'b1;
    @(negedge PCLK);
    err_clr = 1'b0;
    @(negedge PCLK);
  endtask

  int words_before;

  initial begin
    repeat (5) @(negedge PCLK);
    // Reset values
    check_value("rst_rx_valid",   32'(rx_valid),    32'd0);
    check_value("rst_rx_data",    32'(rx_data),     32'h00);
    check_value("rst_busy",       32'(busy),        32'd0);
    check_value("rst_flags",      32'({parity_err, framing_err, break_det, overrun_err}), 32'd0);
    PRESETn  = 1'b1;
    presetn7 = 1'b1;
    wait_ticks(4);
    check_value("idle_busy",      32'(busy),        32'd0);

    // 0xA5, even parity (4 ones -> parity bit 0), one stop bit
    cfg_parity = 2'b01;
    cfg_stop2  = 1'b0;
    send_frame(1'b0, 8, 9'h0A5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_ticks(4);
    check_value("a5_words",       32'(n_words),     32'd1);
    check_value("a5_data",        32'(last_data),   32'hA5);
    check_value("a5_valid_len",   32'(last_run),    32'd1);
    check_value("a5_flags",       32'({parity_err, framing_err, break_det, overrun_err}), 32'd0);

    // 0xF0, odd parity with parity bit 0 -> XOR is 0, parity error
    cfg_parity = 2'b10;
    send_frame(1'b0, 8, 9'h0F0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_ticks(4);
    check_value("f0_data",        32'(last_data),   32'hF0);
    check_value("f0_parity_err",  32'(parity_err),  32'd1);
    check_value("f0_framing_err", 32'(framing_err), 32'd0);
    pulse_clr();
    check_value("f0_clr",         32'(parity_err),  32'd0);

    // 3-tick glitch: line high again before mid-start -> false start
    cfg_parity   = 2'b00;
    words_before = n_words;
    rx = 1'b0;
    wait_ticks(3);
    rx = 1'b1;
    wait_ticks(12);
    check_value("glitch_busy",    32'(busy),        32'd0);
    check_value("glitch_words",   32'(n_words),     32'(words_before));

    // Low for one bit plus 2 ticks, then high: a real start, data all ones
    rx = 1'b0;
    wait_ticks(18);
    rx = 1'b1;
    wait_ticks(160);
    check_value("short_words",    32'(n_words),     32'(words_before + 1));
    check_value("short_data",     32'(last_data),   32'hFF);
    check_value("short_flags",    32'({parity_err, framing_err, break_det, overrun_err}), 32'd0);

    // Break: start, 0x00, stop low, then line held low
    words_before = n_words;
    rx = 1'b0;
    wait_ticks(160 + 48);
    check_value("brk_framing",    32'(framing_err), 32'd1);
    check_value("brk_break",      32'(break_det),   32'd1);
    check_value("brk_data",       32'(last_data),   32'h00);
    check_value("brk_words",      32'(n_words),     32'(words_before + 1));
    wait_ticks(200);
    check_value("brk_no_retrig",  32'(n_words),     32'(words_before + 1));
    check_value("brk_busy",       32'(busy),        32'd0);
    rx = 1'b1;
    wait_ticks(8);
    pulse_clr();
    check_value("brk_clr",        32'({parity_err, framing_err, break_det, overrun_err}), 32'd0);

    // Overrun: 0x11 then 0x22 with no consumer
    rx_ready = 1'b0;
    send_frame(1'b0, 8, 9'h011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(1'b0, 8, 9'h022, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_ticks(4);
    check_value("ovr_overrun",    32'(overrun_err), 32'd1);
    check_value("ovr_data",       32'(rx_data),     32'h22);
    @(negedge PCLK);
    check_value("ovr_valid_held", 32'(rx_valid),    32'd1);
    rx_ready = 1'b1;
    @(negedge PCLK);
    check_value("ovr_valid_drop", 32'(rx_valid),    32'd0);
    pulse_clr();

    // 7-bit instance, two stop bits, second stop bit low
    cfg_stop2 = 1'b1;
    wait_ticks(2);
    send_frame(1'b1, 7, 9'h055, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_ticks(4);
    check_value("s2_framing",     32'(framing_err7), 32'd1);
    check_value("s2_break",       32'(break_det7),   32'd0);
    check_value("s2_valid",       32'(rx_valid7),    32'd1);
    check_value("s2_data",        32'(rx_data7),     32'h55);

    // Asynchronous reset in the middle of the data bits
    rx7 = 1'b0;
    wait_ticks(40);
    check_value("ar_busy_before", 32'(busy7),        32'd1);
    #2;
    presetn7 = 1'b0;
    #1;
    check_value("ar_busy",        32'(busy7),        32'd0);
    check_value("ar_outputs",     32'({rx_valid7, parity_err7, framing_err7, break_det7, overrun_err7}), 32'd0);
    check_value("ar_data",        32'(rx_data7),     32'h00);
    rx7 = 1'b1;
    @(negedge PCLK);
    presetn7 = 1'b1;
    wait_ticks(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
